// File: rtl/gv_pkg.sv
// Shared game-view definitions: game modes, grid geometry and LFSR seed.
// The difficulty stage, note scroller and hit detector all use these.
package gv_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE = 3'd0,
    MODE_PLAY = 3'd1,
    MODE_DIFF = 3'd3
  } mode_t;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  localparam int          SPEED_W   = 23;
  localparam int          LANES     = 4;
  localparam int          ROWS      = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/note_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with a step enable and a synchronous reseed.
// Reseed has priority over stepping; a nonzero seed keeps the register away from zero.
module note_lfsr #(
  parameter logic [15:0] SEED = gv_pkg::LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  input  logic        reseed_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed_i) begin
      lfsr_d = SEED;
    end else if (adv_i) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/note_scroller.sv
// Scrolling note grid: prescales clk by diff_speed into a scroll tick and shifts a LANES x ROWS
// grid toward the hit zone on every tick, spawning new rows from an LFSR.
module note_scroller #(
  parameter int          SPEED_W = gv_pkg::SPEED_W,
  parameter int          LANES   = gv_pkg::LANES,
  parameter int          ROWS    = gv_pkg::ROWS,
  parameter logic [15:0] SEED    = gv_pkg::LFSR_SEED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             mode,
  input  logic [SPEED_W-1:0]     diff_speed,
  output logic                   scroll_tick,
  output logic [LANES*ROWS-1:0]  grid,
  output logic [LANES-1:0]       hit_row,
  output logic [LANES-1:0]       dropped_row,
  output logic [7:0]             spawn_cnt,
  output gv_pkg::run_state_t     dbg_state,
  output logic [15:0]            dbg_lfsr
);

  gv_pkg::run_state_t state_q, state_d;

  logic [SPEED_W-1:0]    cnt_q, cnt_d, thr;
  logic [LANES*ROWS-1:0] grid_q, grid_d;
  logic [LANES-1:0]      dropped_q, dropped_d, new_row;
  logic [7:0]            spawn_q, spawn_d;
  logic                  tick_q, tick_d;
  logic                  play, enter, tick_now;
  logic [15:0]           lfsr;

  assign play = (mode == gv_pkg::MODE_PLAY);
  // Period is max(diff_speed,1); ">=" lets a lowered divisor fire on the next edge.
  assign thr  = (diff_speed == '0) ? '0 : diff_speed - SPEED_W'(1);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= gv_pkg::ST_HOLD;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = play ? gv_pkg::ST_RUN : gv_pkg::ST_HOLD;
  end

  // FSM: outputs. Leaving PLAY always wins over a pending tick.
  always_comb begin
    enter    = (state_q == gv_pkg::ST_HOLD) && play;
    tick_now = (state_q == gv_pkg::ST_RUN) && play && (cnt_q >= thr);
  end

  always_comb begin
    cnt_d     = '0;
    tick_d    = 1'b0;
    grid_d    = grid_q;
    dropped_d = dropped_q;
    spawn_d   = spawn_q;
    new_row   = (lfsr[7:6] != 2'b00) ? lfsr[LANES-1:0] : '0;
    if (enter) begin
      grid_d    = '0;
      dropped_d = '0;
      spawn_d   = '0;
    end else if (tick_now) begin
      tick_d    = 1'b1;
      grid_d    = {grid_q[LANES*(ROWS-1)-1:0], new_row};
      dropped_d = grid_q[LANES*ROWS-1 -: LANES];
      if ((new_row != '0) && (spawn_q != 8'hFF)) spawn_d = spawn_q + 8'd1;
    end else if ((state_q == gv_pkg::ST_RUN) && play) begin
      cnt_d = cnt_q + SPEED_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      grid_q    <= '0;
      dropped_q <= '0;
      spawn_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      grid_q    <= grid_d;
      dropped_q <= dropped_d;
      spawn_q   <= spawn_d;
    end
  end

  note_lfsr #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .adv_i    (tick_now),
    .reseed_i (enter),
    .lfsr_o   (lfsr)
  );

  assign scroll_tick = tick_q;
  assign grid        = grid_q;
  assign hit_row     = grid_q[LANES*ROWS-1 -: LANES];
  assign dropped_row = dropped_q;
  assign spawn_cnt   = spawn_q;
  assign dbg_state   = state_q;
  assign dbg_lfsr    = lfsr;

endmodule

// File: tb/tb_note_scroller.sv
// Bench for note_scroller: a row-queue reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_note_scroller;

  localparam int SW = 23;
  localparam int LN = 4;
  localparam int RW = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [2:0]          mode = 3'd0;
  logic [SW-1:0]       diff_speed = 23'd4;
  logic                scroll_tick;
  logic [LN*RW-1:0]    grid;
  logic [LN-1:0]       hit_row;
  logic [LN-1:0]       dropped_row;
  logic [7:0]          spawn_cnt;
  gv_pkg::run_state_t  dbg_state;
  logic [15:0]         dbg_lfsr;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  int tick_seen;

  note_scroller dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .diff_speed  (diff_speed),
    .scroll_tick (scroll_tick),
    .grid        (grid),
    .hit_row     (hit_row),
    .dropped_row (dropped_row),
    .spawn_cnt   (spawn_cnt),
    .dbg_state   (dbg_state),
    .dbg_lfsr    (dbg_lfsr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: rows kept as a list, spawn/scroll rules applied per clock edge.
  logic [LN-1:0] m_rows[RW];
  logic [LN-1:0] m_dropped;
  logic [15:0]   m_lfsr;
  logic          m_tick;
  logic          m_run;
  int            m_elapsed;
  int            m_spawn;

  function automatic logic [LN*RW-1:0] m_grid();
    logic [LN*RW-1:0] g;
    g = '0;
    for (int r = 0; r < RW; r++) g[r*LN +: LN] = m_rows[r];
    return g;
  endfunction

  always @(posedge clk or posedge rst) begin
    int period;
    logic [LN-1:0] nr;
    if (rst) begin
      for (int r = 0; r < RW; r++) m_rows[r] = '0;
      m_dropped = '0; m_lfsr = 16'hACE1; m_tick = 1'b0; m_run = 1'b0;
      m_elapsed = 0; m_spawn = 0;
    end else if (mode != 3'd1) begin
      m_run = 1'b0; m_elapsed = 0; m_tick = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_elapsed = 0; m_tick = 1'b0; m_lfsr = 16'hACE1;
      for (int r = 0; r < RW; r++) m_rows[r] = '0;
      m_dropped = '0; m_spawn = 0;
    end else begin
      period = (diff_speed == 0) ? 1 : int'(diff_speed);
      if (m_elapsed + 1 >= period) begin
        m_tick    = 1'b1;
        m_elapsed = 0;
        m_dropped = m_rows[RW-1];
        for (int r = RW-1; r > 0; r--) m_rows[r] = m_rows[r-1];
        nr = (m_lfsr[7:6] != 2'b00) ? m_lfsr[LN-1:0] : '0;
        m_rows[0] = nr;
        if (nr != 0 && m_spawn < 255) m_spawn++;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end else begin
        m_tick = 1'b0;
        m_elapsed++;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("grid", grid, m_grid());
      check("hit_row", hit_row, m_rows[RW-1]);
      check("scroll_tick", scroll_tick, m_tick);
      check("dropped_row", dropped_row, m_dropped);
      check("spawn_cnt", spawn_cnt, m_spawn[7:0]);
      check("state", dbg_state, m_run ? gv_pkg::ST_RUN : gv_pkg::ST_HOLD);
      check("lfsr", dbg_lfsr, m_lfsr);
      check("lfsr_nonzero", dbg_lfsr != 16'h0, 1'b1);
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (scroll_tick) tick_seen++;
    end
  endtask

  task automatic go_idle();
    mode = 3'd0;
    cycles(2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    cycles(2);

    // entry with diff_speed=4: ticks on the 4th edge after entry
    diff_speed = 23'd4;
    mode = 3'd1;
    cycles(1);
    tick_seen = 0;
    cycles(3);
    check("t2_no_early_tick", tick_seen, 0);
    cycles(1);
    check("t2_first_tick", scroll_tick, 1'b1);
    check("t2_first_row", grid[3:0], 4'b0001);
    check("t2_spawn1", spawn_cnt, 8'd1);
    tick_seen = 0;
    cycles(16);
    check("t2_tick_rate", tick_seen, 4);

    // asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    check("rst_grid", grid, '0);
    check("rst_tick", scroll_tick, 1'b0);
    check("rst_dropped", dropped_row, 4'b0);
    check("rst_spawn", spawn_cnt, 8'd0);
    check("rst_lfsr", dbg_lfsr, 16'hACE1);
    mode = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    cycles(2);

    // diff_speed=1 then 0: tick every clock
    diff_speed = 23'd1;
    mode = 3'd1;
    cycles(1);
    cycles(8);
    check("t3_hit_row", hit_row, 4'b0001);
    cycles(1);
    check("t3_dropped", dropped_row, 4'b0001);
    diff_speed = 23'd0;
    tick_seen = 0;
    cycles(20);
    check("t3_ds0_rate", tick_seen, 20);
    go_idle();

    // lowering diff_speed mid-count ticks on the next edge
    diff_speed = 23'd100;
    mode = 3'd1;
    cycles(1);
    tick_seen = 0;
    cycles(60);
    check("t4_no_tick_60", tick_seen, 0);
    diff_speed = 23'd10;
    cycles(1);
    check("t4_immediate_tick", scroll_tick, 1'b1);
    tick_seen = 0;
    cycles(30);
    check("t4_rate10", tick_seen, 3);
    go_idle();

    // leave PLAY mid-count, then re-enter
    diff_speed = 23'd7;
    mode = 3'd1;
    cycles(10);
    mode = 3'd3;
    tick_seen = 0;
    cycles(50);
    check("t5_frozen_ticks", tick_seen, 0);
    mode = 3'd1;
    cycles(1);
    check("t5_spawn_clear", spawn_cnt, 8'd0);
    check("t5_grid_clear", grid, '0);
    cycles(6);
    check("t5_no_tick_yet", scroll_tick, 1'b0);
    cycles(1);
    check("t5_tick", scroll_tick, 1'b1);
    check("t5_first_row", grid[3:0], 4'b0001);
    go_idle();

    // long run to saturate spawn_cnt
    diff_speed = 23'd2;
    mode = 3'd1;
    cycles(1);
    tick_seen = 0;
    cycles(2000);
    check("t6_ticks", tick_seen, 1000);
    check("t6_spawn_sat", spawn_cnt, 8'hFF);
    go_idle();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
